// File: rtl/exe_stage_if.sv
// Decode -> execute -> EXE/MEM bundle.
// The master side (decode stage / environment) drives the decoded instruction
// and observes stall, branch redirect and the registered EXE/MEM bundle.
interface exe_stage_if #(
   parameter int DATA_W = 32
);
   // decoded instruction from the decode stage
   logic              in_valid;
   logic [DATA_W-1:0] PC;
   logic [DATA_W-1:0] Val1;
   logic [DATA_W-1:0] Val2;
   logic [DATA_W-1:0] Reg2;
   logic [4:0]        Dest;
   logic [3:0]        EXE_CMD;
   logic [1:0]        Br_type;
   logic              MEM_R_EN;
   logic              MEM_W_EN;
   logic              WB_EN;

   // combinational feedback to fetch/decode
   logic              Stall;
   logic              Br_taken;
   logic [DATA_W-1:0] Br_addr;

   // registered EXE/MEM bundle
   logic              out_valid;
   logic [DATA_W-1:0] ALU_Result;
   logic [DATA_W-1:0] Reg2_out;
   logic [4:0]        Dest_out;
   logic              MEM_R_EN_out;
   logic              MEM_W_EN_out;
   logic              WB_EN_out;

   modport master (
      output in_valid, PC, Val1, Val2, Reg2, Dest, EXE_CMD, Br_type,
             MEM_R_EN, MEM_W_EN, WB_EN,
      input  Stall, Br_taken, Br_addr,
             out_valid, ALU_Result, Reg2_out, Dest_out,
             MEM_R_EN_out, MEM_W_EN_out, WB_EN_out
   );

   modport slave (
      input  in_valid, PC, Val1, Val2, Reg2, Dest, EXE_CMD, Br_type,
             MEM_R_EN, MEM_W_EN, WB_EN,
      output Stall, Br_taken, Br_addr,
             out_valid, ALU_Result, Reg2_out, Dest_out,
             MEM_R_EN_out, MEM_W_EN_out, WB_EN_out
   );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, iterative shift-add multiplier that stalls
// the front end, combinational branch resolution, registered EXE/MEM bundle.
module exe_stage #(
   parameter int DATA_W    = 32,
   parameter int MUL_RADIX = 1
) (
   input  logic       clk,
   input  logic       rst,
   exe_stage_if.slave bus
);

   localparam int N_ITER = DATA_W / MUL_RADIX;
   localparam int CNT_W  = $clog2(N_ITER + 1);

   localparam logic [3:0] CMD_ADD = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0001;
   localparam logic [3:0] CMD_AND = 4'b0010;
   localparam logic [3:0] CMD_OR  = 4'b0011;
   localparam logic [3:0] CMD_NOR = 4'b0100;
   localparam logic [3:0] CMD_XOR = 4'b0101;
   localparam logic [3:0] CMD_SLL = 4'b0110;
   localparam logic [3:0] CMD_SRA = 4'b0111;
   localparam logic [3:0] CMD_SRL = 4'b1000;
   localparam logic [3:0] CMD_MUL = 4'b1001;
   localparam logic [3:0] CMD_SLT = 4'b1010;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL_RUN,
      S_MUL_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_stall;
   logic              w_is_mul;
   logic              w_accept_alu;
   logic              w_start_mul;
   logic              w_br_cond;
   logic [DATA_W-1:0] w_alu_res;

   // multiplier working set and the control captured with it
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0] r_mplier;
   logic [DATA_W-1:0] r_reg2_cap;
   logic [4:0]        r_dest_cap;
   logic              r_mr_cap;
   logic              r_mw_cap;
   logic              r_wb_cap;

   // EXE/MEM bundle
   logic              r_out_valid;
   logic [DATA_W-1:0] r_alu_result;
   logic [DATA_W-1:0] r_reg2_out;
   logic [4:0]        r_dest_out;
   logic              r_mr_out;
   logic              r_mw_out;
   logic              r_wb_out;

   // Single-cycle ALU; unknown opcodes and NOP yield zero
   function automatic logic [DATA_W-1:0] alu(input logic [3:0]        cmd,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
      logic signed [DATA_W-1:0] sa;
      logic signed [DATA_W-1:0] sb;
      logic [4:0]               sh;
      logic [DATA_W-1:0]        res;
      sa = signed'(a);
      sb = signed'(b);
      sh = b[4:0];
      case (cmd)
         CMD_ADD: res = a + b;
         CMD_SUB: res = a - b;
         CMD_AND: res = a & b;
         CMD_OR:  res = a | b;
         CMD_NOR: res = ~(a | b);
         CMD_XOR: res = a ^ b;
         CMD_SLL: res = a << sh;
         CMD_SRA: res = unsigned'(sa >>> sh);
         CMD_SRL: res = a >> sh;
         CMD_SLT: res = {{(DATA_W-1){1'b0}}, (sa < sb)};
         default: res = '0;
      endcase
      return res;
   endfunction

   // One shift-add iteration retiring MUL_RADIX multiplier bits
   function automatic logic [DATA_W-1:0] mul_step(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] mcand,
                                                  input logic [DATA_W-1:0] mplier);
      logic [DATA_W-1:0] sum;
      sum = acc;
      for (int k = 0; k < MUL_RADIX; k++) begin
         if (mplier[k]) sum = sum + (mcand << k);
      end
      return sum;
   endfunction

   assign w_is_mul     = (bus.EXE_CMD == CMD_MUL);
   assign w_accept_alu = bus.in_valid && (r_state == S_IDLE) && !w_is_mul;
   assign w_start_mul  = bus.in_valid && (r_state == S_IDLE) && w_is_mul;
   assign w_alu_res    = alu(bus.EXE_CMD, bus.Val1, bus.Val2);

   // Branch condition selected by Br_type
   always_comb begin
      w_br_cond = 1'b0;
      case (bus.Br_type)
         2'b01:   w_br_cond = (bus.Val1 == '0);
         2'b10:   w_br_cond = (bus.Val1 != bus.Reg2);
         2'b11:   w_br_cond = 1'b1;
         default: w_br_cond = 1'b0;
      endcase
   end

   assign bus.Br_taken = w_accept_alu && w_br_cond;
   assign bus.Br_addr  = bus.PC + (bus.Val2 << 2);
   assign bus.Stall    = w_stall;

   // FSM next state and stall
   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_mul) begin
               w_state_nxt = S_MUL_RUN;
               w_stall     = 1'b1;
            end
         end
         S_MUL_RUN: begin
            w_stall = 1'b1;
            if (r_cnt == CNT_W'(N_ITER - 1)) w_state_nxt = S_MUL_DONE;
         end
         S_MUL_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Iteration counter: cleared on start, counts RUN cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (w_start_mul) begin
         r_cnt <= '0;
      end else if (r_state == S_MUL_RUN) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Multiplier datapath and captured control; decode inputs are ignored after start
   always_ff @(posedge clk) begin
      if (w_start_mul) begin
         r_acc      <= '0;
         r_mcand    <= bus.Val1;
         r_mplier   <= bus.Val2;
         r_reg2_cap <= bus.Reg2;
         r_dest_cap <= bus.Dest;
         r_mr_cap   <= bus.MEM_R_EN;
         r_mw_cap   <= bus.MEM_W_EN;
         r_wb_cap   <= bus.WB_EN;
      end else if (r_state == S_MUL_RUN) begin
         r_acc    <= mul_step(r_acc, r_mcand, r_mplier);
         r_mcand  <= r_mcand << MUL_RADIX;
         r_mplier <= r_mplier >> MUL_RADIX;
      end
   end

   // EXE/MEM register: product on MUL_DONE, ALU result on accept, else bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid  <= 1'b0;
         r_alu_result <= '0;
         r_reg2_out   <= '0;
         r_dest_out   <= '0;
         r_mr_out     <= 1'b0;
         r_mw_out     <= 1'b0;
         r_wb_out     <= 1'b0;
      end else if (r_state == S_MUL_DONE) begin
         r_out_valid  <= 1'b1;
         r_alu_result <= r_acc;
         r_reg2_out   <= r_reg2_cap;
         r_dest_out   <= r_dest_cap;
         r_mr_out     <= r_mr_cap;
         r_mw_out     <= r_mw_cap;
         r_wb_out     <= r_wb_cap;
      end else if (w_accept_alu) begin
         r_out_valid  <= 1'b1;
         r_alu_result <= w_alu_res;
         r_reg2_out   <= bus.Reg2;
         r_dest_out   <= bus.Dest;
         r_mr_out     <= bus.MEM_R_EN;
         r_mw_out     <= bus.MEM_W_EN;
         r_wb_out     <= bus.WB_EN;
      end else begin
         r_out_valid  <= 1'b0;
         r_mr_out     <= 1'b0;
         r_mw_out     <= 1'b0;
         r_wb_out     <= 1'b0;
      end
   end

   assign bus.out_valid    = r_out_valid;
   assign bus.ALU_Result   = r_alu_result;
   assign bus.Reg2_out     = r_reg2_out;
   assign bus.Dest_out     = r_dest_out;
   assign bus.MEM_R_EN_out = r_mr_out;
   assign bus.MEM_W_EN_out = r_mw_out;
   assign bus.WB_EN_out    = r_wb_out;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: radix-1 and radix-2 instances share stimulus;
// expected EXE/MEM bundles go into a queue at issue and are popped on out_valid.
module tb_exe_stage;

   localparam int DW = 32;

   localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010, OR_ = 4'b0011,
                          NOR_ = 4'b0100, XOR_ = 4'b0101, SLL = 4'b0110, SRA = 4'b0111,
                          SRL = 4'b1000, MUL = 4'b1001, SLT = 4'b1010, NOP = 4'b1111;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          t_valid;
   logic [DW-1:0] t_pc, t_v1, t_v2, t_r2;
   logic [4:0]    t_dest;
   logic [3:0]    t_cmd;
   logic [1:0]    t_brt;
   logic          t_mr, t_mw, t_wb;
   bit            sel;

   exe_stage_if #(.DATA_W(DW)) b1();
   exe_stage_if #(.DATA_W(DW)) b2();

   exe_stage #(.DATA_W(DW), .MUL_RADIX(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
   exe_stage #(.DATA_W(DW), .MUL_RADIX(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

   assign b1.in_valid = t_valid;  assign b2.in_valid = t_valid;
   assign b1.PC       = t_pc;     assign b2.PC       = t_pc;
   assign b1.Val1     = t_v1;     assign b2.Val1     = t_v1;
   assign b1.Val2     = t_v2;     assign b2.Val2     = t_v2;
   assign b1.Reg2     = t_r2;     assign b2.Reg2     = t_r2;
   assign b1.Dest     = t_dest;   assign b2.Dest     = t_dest;
   assign b1.EXE_CMD  = t_cmd;    assign b2.EXE_CMD  = t_cmd;
   assign b1.Br_type  = t_brt;    assign b2.Br_type  = t_brt;
   assign b1.MEM_R_EN = t_mr;     assign b2.MEM_R_EN = t_mr;
   assign b1.MEM_W_EN = t_mw;     assign b2.MEM_W_EN = t_mw;
   assign b1.WB_EN    = t_wb;     assign b2.WB_EN    = t_wb;

   wire          o_stall = sel ? b2.Stall        : b1.Stall;
   wire          o_br    = sel ? b2.Br_taken     : b1.Br_taken;
   wire [DW-1:0] o_braddr= sel ? b2.Br_addr      : b1.Br_addr;
   wire          o_valid = sel ? b2.out_valid    : b1.out_valid;
   wire [DW-1:0] o_res   = sel ? b2.ALU_Result   : b1.ALU_Result;
   wire [DW-1:0] o_r2    = sel ? b2.Reg2_out     : b1.Reg2_out;
   wire [4:0]    o_dest  = sel ? b2.Dest_out     : b1.Dest_out;
   wire          o_mr    = sel ? b2.MEM_R_EN_out : b1.MEM_R_EN_out;
   wire          o_mw    = sel ? b2.MEM_W_EN_out : b1.MEM_W_EN_out;
   wire          o_wb    = sel ? b2.WB_EN_out    : b1.WB_EN_out;

   typedef struct {
      logic [DW-1:0] res;
      logic [DW-1:0] r2;
      logic [4:0]    dest;
      logic [2:0]    ctl;   // {mr, mw, wb}
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic put(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [31:0] r2, input logic [4:0] d, input logic [1:0] brt,
                      input logic mr, input logic mw, input logic wb, input logic [31:0] pc);
      t_valid = 1'b1; t_cmd = cmd; t_v1 = v1; t_v2 = v2; t_r2 = r2; t_dest = d;
      t_brt = brt; t_mr = mr; t_mw = mw; t_wb = wb; t_pc = pc;
   endtask

   task automatic idle_in();
      t_valid = 1'b0; t_cmd = NOP; t_v1 = '0; t_v2 = '0; t_r2 = '0; t_dest = '0;
      t_brt = 2'b00; t_mr = 1'b0; t_mw = 1'b0; t_wb = 1'b0; t_pc = '0;
   endtask

   task automatic push(input logic [31:0] res, input logic [31:0] r2, input logic [4:0] d,
                       input logic mr, input logic mw, input logic wb);
      exp_t e;
      e.res = res; e.r2 = r2; e.dest = d; e.ctl = {mr, mw, wb};
      q.push_back(e);
   endtask

   // advance one clock, then check the registered bundle against the scoreboard
   task automatic step(input logic exp_valid, input string tag);
      exp_t e;
      @(posedge clk); #1;
      chk({tag, ".valid"}, 32'(o_valid), 32'(exp_valid));
      if (o_valid === 1'b1) begin
         if (q.size() == 0) begin
            checks++; failures++;
            $error("FAIL %s.unexpected observed=0x%0h expected=none", tag, o_res);
         end else begin
            e = q.pop_front();
            chk({tag, ".res"},  o_res, e.res);
            chk({tag, ".reg2"}, o_r2, e.r2);
            chk({tag, ".dest"}, 32'(o_dest), 32'(e.dest));
            chk({tag, ".ctl"},  32'({o_mr, o_mw, o_wb}), 32'(e.ctl));
         end
      end else begin
         chk({tag, ".bubble_en"}, 32'({o_mr, o_mw, o_wb}), 32'd0);
      end
   endtask

   // single-cycle op with writeback to d; result checked one cycle later
   task automatic alu_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic [31:0] expv, input string tag);
      put(cmd, a, b, 32'h0, d, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
      push(expv, 32'h0, d, 1'b0, 1'b0, 1'b1);
      #4;
      chk({tag, ".stall"}, 32'(o_stall), 32'd0);
      step(1'b1, tag);
   endtask

   task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                          input int exp_stall, input string tag);
      int  n;
      bit  done;
      n = 0; done = 0;
      put(MUL, a, b, 32'h55, 5'd7, 2'b11, 1'b0, 1'b0, 1'b1, 32'h40);
      push(expv, 32'h55, 5'd7, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 100; i++) begin
         #4;
         if (i == 0) chk({tag, ".br"}, 32'(o_br), 32'd0);
         if (i == 3) begin
            t_v1 = 32'h1234_5678; t_v2 = 32'h9; t_dest = 5'd1; t_r2 = 32'hAA;
         end
         if (o_stall === 1'b1) begin
            n++;
            step(1'b0, tag);
         end else begin
            step(1'b1, tag);
            done = 1;
            break;
         end
      end
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".stall_cycles"}, n, exp_stall);
      idle_in();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      sel = 1'b0;
      rst = 1'b0;
      idle_in();
      repeat (3) @(posedge clk);
      #1;
      chk("rst.valid", 32'(o_valid), 32'd0);
      chk("rst.res",   o_res, 32'd0);
      chk("rst.dest",  32'(o_dest), 32'd0);
      chk("rst.wb",    32'(o_wb), 32'd0);
      chk("rst.stall", 32'(o_stall), 32'd0);
      rst = 1'b1;
      step(1'b0, "idle0");

      alu_op(ADD,  32'd5,          32'd7,  5'd3, 32'd12,         "add");
      alu_op(SUB,  32'd3,          32'd5,  5'd4, 32'hFFFF_FFFE,  "sub");
      alu_op(SRA,  32'h8000_0000,  32'd4,  5'd5, 32'hF800_0000,  "sra");
      alu_op(SLT,  32'hFFFF_FFFF,  32'd1,  5'd6, 32'd1,          "slt_t");
      alu_op(SLT,  32'd1,  32'hFFFF_FFFF,  5'd6, 32'd0,          "slt_f");
      alu_op(SRL,  32'h8000_0000,  32'd4,  5'd8, 32'h0800_0000,  "srl");
      alu_op(SLL,  32'd1,          32'd31, 5'd9, 32'h8000_0000,  "sll");
      alu_op(NOR_, 32'h0F0F_0000,  32'h0000_00F0, 5'd10, 32'hF0F0_FF0F, "nor");
      alu_op(XOR_, 32'hFF00_FF00,  32'h0FF0_0FF0, 5'd11, 32'hF0F0_F0F0, "xor");
      alu_op(AND_, 32'hFF00_FF00,  32'h0FF0_0FF0, 5'd12, 32'h0F00_0F00, "and");
      alu_op(OR_,  32'hFF00_0000,  32'h0000_00FF, 5'd13, 32'hFF00_00FF, "or");
      alu_op(ADD,  32'hFFFF_FFFF,  32'd1,  5'd14, 32'd0,          "add_wrap");
      alu_op(NOP,  32'd9,          32'd9,  5'd15, 32'd0,          "nop");
      alu_op(4'b1011, 32'd9,       32'd9,  5'd16, 32'd0,          "undef");

      // store: address = base + offset, store data travels in Reg2_out
      put(ADD, 32'h1000, 32'h24, 32'hDEAD_BEEF, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
      push(32'h1024, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0);
      step(1'b1, "store");
      idle_in();
      #4;
      chk("idle.br", 32'(o_br), 32'd0);
      step(1'b0, "idle1");

      // branches
      put(NOP, 32'd1, 32'd4, 32'd2, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h100);
      push(32'd0, 32'd2, 5'd0, 1'b0, 1'b0, 1'b0);
      #4;
      chk("bne.taken", 32'(o_br), 32'd1);
      chk("bne.addr",  o_braddr, 32'h110);
      step(1'b1, "bne");
      put(NOP, 32'd2, 32'd4, 32'd2, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h100);
      push(32'd0, 32'd2, 5'd0, 1'b0, 1'b0, 1'b0);
      #4;
      chk("bne_eq.taken", 32'(o_br), 32'd0);
      step(1'b1, "bne_eq");
      put(NOP, 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h200);
      push(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #4;
      chk("bez.taken", 32'(o_br), 32'd1);
      chk("bez.addr",  o_braddr, 32'h1FC);
      step(1'b1, "bez");
      put(NOP, 32'd3, 32'd1, 32'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h200);
      push(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #4;
      chk("bez_nz.taken", 32'(o_br), 32'd0);
      step(1'b1, "bez_nz");
      put(NOP, 32'd3, 32'd2, 32'd3, 5'd0, 2'b11, 1'b0, 1'b0, 1'b0, 32'h300);
      push(32'd0, 32'd3, 5'd0, 1'b0, 1'b0, 1'b0);
      #4;
      chk("jmp.taken", 32'(o_br), 32'd1);
      chk("jmp.addr",  o_braddr, 32'h308);
      step(1'b1, "jmp");
      put(NOP, 32'd3, 32'd2, 32'd4, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h300);
      push(32'd0, 32'd4, 5'd0, 1'b0, 1'b0, 1'b0);
      #4;
      chk("none.taken", 32'(o_br), 32'd0);
      step(1'b1, "none");
      idle_in();
      step(1'b0, "idle2");

      // multiplier, radix 1
      run_mul(32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 33, "mul1");
      run_mul(32'h8000_0000, 32'd2,         32'd0,         33, "mul2");
      alu_op(ADD, 32'd100, 32'd23, 5'd20, 32'd123, "add_after_mul");
      idle_in();
      step(1'b0, "idle3");

      // reset during MUL_RUN cycle 10
      put(MUL, 32'd77, 32'd3, 32'd0, 5'd2, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
      for (int i = 0; i < 11; i++) begin
         #4;
         chk("abort.stall", 32'(o_stall), 32'd1);
         step(1'b0, "abort");
      end
      #2;
      rst = 1'b0;
      #1;
      chk("abort.valid", 32'(o_valid), 32'd0);
      chk("abort.res",   o_res, 32'd0);
      chk("abort.wb",    32'(o_wb), 32'd0);
      idle_in();
      #1;
      chk("abort.idle_stall", 32'(o_stall), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b0, "post_abort");
      alu_op(ADD, 32'd40, 32'd2, 5'd21, 32'd42, "add_after_abort");
      idle_in();
      step(1'b0, "idle4");

      // radix-2 instance: fresh reset, then MUL immediately followed by ADD
      rst = 1'b0;
      q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      sel = 1'b1;
      step(1'b0, "r2_idle");
      run_mul(32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 17, "r2_mul");
      alu_op(ADD, 32'd10, 32'd20, 5'd22, 32'd30, "r2_add");
      for (int i = 0; i < 2; i++) begin
         ra = $urandom;
         rb = $urandom;
         run_mul(ra, rb, ra * rb, 17, "r2_mul_rand");
      end
      idle_in();
      step(1'b0, "r2_idle_end");
      chk("queue_empty", q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
